// File: rtl/bit_stream_scheduler_if.sv
// Bundle of requester-side and detector-side signals for bit_stream_scheduler.
// Handshake: a requester holds req[i] high with word[i] stable until it sees the
// one-cycle gnt[i] pulse; the word is sampled only in that cycle. ser_bit is
// frame data only while bit_valid is high. done pulses once per frame, and
// done_id/hits stay valid until the next done.
interface bit_stream_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] word;
  logic [NREQ-1:0]       gnt;
  logic                  ser_bit;
  logic                  bit_valid;
  logic                  det_rst;
  logic                  det;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CW-1:0]         hits;
  logic                  busy;

  modport master (
    input  req, word, det,
    output gnt, ser_bit, bit_valid, det_rst, done, done_id, hits, busy
  );

  modport slave (
    output req, word, det,
    input  gnt, ser_bit, bit_valid, det_rst, done, done_id, hits, busy
  );
endinterface

// File: rtl/bit_stream_scheduler.sv
// Round-robin sharing of one serial pattern detector: grant, clear detector,
// shift the winner's word MSB-first, count detector hits, report the count.
module bit_stream_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IDW   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  bit_stream_scheduler_if.master        bus,
  output logic [2:0]                    fsm_state
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam int CNTW = $clog2(WIDTH);

  logic [2:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  bit_cnt;
  logic [CW-1:0]    hit_cnt;
  logic             win;
  logic [IDW-1:0]   done_id_q;
  logic [CW-1:0]    hits_q;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    hit_next;
  logic [NREQ-1:0]  gnt_vec;

  // Scan from the farthest offset down so the nearest requester at or after
  // ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    cand       = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + IDW'(k);
      if (bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    load_word = '0;
    gnt_vec   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx == IDW'(i)) begin
        load_word  = bus.word[i*WIDTH +: WIDTH];
        gnt_vec[i] = (state == S_LOAD);
      end
    end
  end

  // win lags bit_valid by one cycle so the detector's response to each bit,
  // including the last one, lands inside the counting window.
  always_comb begin
    hit_next = hit_cnt;
    if (win && bus.det && (hit_cnt != {CW{1'b1}}))
      hit_next = hit_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      hit_cnt   <= '0;
      win       <= 1'b0;
      done_id_q <= '0;
      hits_q    <= '0;
    end else begin
      win     <= (state == S_SHIFT);
      hit_cnt <= hit_next;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            idx   <= pick_idx;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg   <= load_word;
          bit_cnt <= '0;
          hit_cnt <= '0;
          ptr     <= idx + IDW'(1);
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNTW'(1);
          if (bit_cnt == CNTW'(WIDTH - 1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          hits_q    <= hit_next;
          done_id_q <= idx;
          state     <= S_REPORT;
        end
        S_REPORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // det_rst follows rst combinationally so the detector is held clear for the
  // whole reset, not just from the cycle after it.
  assign bus.gnt       = gnt_vec;
  assign bus.ser_bit   = (state == S_SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign bus.bit_valid = (state == S_SHIFT);
  assign bus.det_rst   = rst || (state == S_LOAD);
  assign bus.done      = (state == S_REPORT);
  assign bus.done_id   = done_id_q;
  assign bus.hits      = hits_q;
  assign bus.busy      = (state != S_IDLE);
  assign fsm_state     = state;
endmodule

// File: tb/tb_bit_stream_scheduler.sv
// Directed bench for bit_stream_scheduler: two instances (CW=4 and CW=3) share
// identical stimulus so counter saturation can be seen against the wide one.
module tb_bit_stream_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] word = '0;
  logic        det = 1'b0;
  logic [2:0]  st_a;
  logic [2:0]  st_b;
  int          cyc = 0;
  int          vecs = 0;
  int          errs = 0;

  bit_stream_scheduler_if #(.NREQ(4), .WIDTH(8), .CW(4), .IDW(2)) a_if ();
  bit_stream_scheduler_if #(.NREQ(4), .WIDTH(8), .CW(3), .IDW(2)) b_if ();

  assign a_if.req  = req;
  assign a_if.word = word;
  assign a_if.det  = det;
  assign b_if.req  = req;
  assign b_if.word = word;
  assign b_if.det  = det;

  bit_stream_scheduler #(.NREQ(4), .WIDTH(8), .CW(4), .IDW(2)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.master), .fsm_state(st_a)
  );
  bit_stream_scheduler #(.NREQ(4), .WIDTH(8), .CW(3), .IDW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.master), .fsm_state(st_b)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int at);
    g  = '0;
    at = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (a_if.gnt != 4'b0000) begin
        g  = a_if.gnt;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (a_if.done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [7:0]  w;
    logic [3:0]  g;
    logic        ok;
    int          at;
    int          prev;

    // reset state
    tick(); tick();
    chk("rst_det_rst", a_if.det_rst, 1'b1);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_gnt", a_if.gnt, 4'b0000);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_hits", a_if.hits, 4'd0);
    chk("rst_bit_valid", a_if.bit_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_det_rst", a_if.det_rst, 1'b0);

    // single frame, requester 2, word A5, det at t2,t3,t5,t10
    w = 8'hA5;
    word[23:16] = w;
    tick();
    req = 4'b0100;
    #1;
    chk("t0_busy", a_if.busy, 1'b0);
    tick();
    req = 4'b0000;
    #1;
    chk("t1_gnt", a_if.gnt, 4'b0100);
    chk("t1_det_rst", a_if.det_rst, 1'b1);
    chk("t1_busy", a_if.busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      det = (i == 0) || (i == 1) || (i == 3);
      #1;
      chk($sformatf("shift_bit%0d", i), a_if.ser_bit, w[7-i]);
      chk($sformatf("shift_valid%0d", i), a_if.bit_valid, 1'b1);
      chk($sformatf("shift_busy%0d", i), a_if.busy, 1'b1);
      chk($sformatf("shift_det_rst%0d", i), a_if.det_rst, 1'b0);
    end
    tick();
    det = 1'b1;
    #1;
    chk("drain_valid", a_if.bit_valid, 1'b0);
    chk("drain_bit", a_if.ser_bit, 1'b0);
    chk("drain_done", a_if.done, 1'b0);
    tick();
    det = 1'b0;
    #1;
    chk("report_done", a_if.done, 1'b1);
    chk("report_id", a_if.done_id, 2'd2);
    chk("report_hits_a", a_if.hits, 4'd3);
    chk("report_hits_b", b_if.hits, 3'd3);
    chk("report_busy", a_if.busy, 1'b1);
    tick();
    chk("post_done", a_if.done, 1'b0);
    chk("post_busy", a_if.busy, 1'b0);
    chk("post_hits_hold", a_if.hits, 4'd3);
    chk("post_id_hold", a_if.done_id, 2'd2);

    // round robin with all requesting, pointer restarted from 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    wait_gnt(g, at);
    chk("rr_gnt0", g, 4'b0001);
    prev = at;
    for (int k = 1; k < 5; k++) begin
      wait_gnt(g, at);
      if (k == 4) req = 4'b0010;
      chk($sformatf("rr_gnt%0d", k), g, 4'b0001 << (k % 4));
      chk($sformatf("rr_space%0d", k), at - prev, 12);
      prev = at;
    end

    // grant to 1, then wrap search from pointer 2 to requester 0
    wait_gnt(g, at);
    chk("wrap_gnt1", g, 4'b0010);
    req = 4'b0011;
    wait_gnt(g, at);
    chk("wrap_gnt0", g, 4'b0001);
    wait_gnt(g, at);
    chk("wrap_gnt_next", g, 4'b0010);
    req = 4'b0000;
    wait_done(ok);
    chk("wrap_done_seen", ok, 1'b1);
    chk("wrap_done_id", a_if.done_id, 2'd1);

    // det held high across a whole frame: 8 hits, 3-bit counter saturates at 7
    word[7:0] = 8'h3C;
    det = 1'b1;
    req = 4'b0001;
    wait_gnt(g, at);
    chk("sat_gnt", g, 4'b0001);
    req = 4'b0000;
    wait_done(ok);
    chk("sat_done_seen", ok, 1'b1);
    chk("sat_hits_a", a_if.hits, 4'd8);
    chk("sat_hits_b", b_if.hits, 3'd7);
    chk("sat_id", a_if.done_id, 2'd0);
    det = 1'b0;

    // reset in the middle of SHIFT aborts the frame
    req = 4'b1111;
    wait_gnt(g, at);
    chk("abort_gnt", g, 4'b0010);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_det_rst", a_if.det_rst, 1'b1);
    chk("abort_pre_valid", a_if.bit_valid, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", a_if.bit_valid, 1'b0);
    chk("abort_busy", a_if.busy, 1'b0);
    chk("abort_hits", a_if.hits, 4'd0);
    chk("abort_done", a_if.done, 1'b0);
    chk("abort_gnt_idle", a_if.gnt, 4'b0000);
    tick();
    chk("abort_next_gnt", a_if.gnt, 4'b0001);
    chk("abort_next_det_rst", a_if.det_rst, 1'b1);
    req = 4'b0000;
    wait_done(ok);
    chk("abort_after_done", ok, 1'b1);
    chk("abort_after_id", a_if.done_id, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/bit_stream_scheduler.md
Name: bit_stream_scheduler

Overview:
Shares one serial pattern detector among NREQ requesters. Each requester presents a parallel word. A round-robin arbiter picks one requester. The block clears the detector, shifts the word out MSB-first one bit per cycle, and counts the detector's match pulses. It returns the hit count to the winner with a one-cycle DONE.

Parameters:
NREQ, 4, number of requesters (power of 2, >=2)
WIDTH, 8, bits per word / frame length (>=2)
CW, 4, width of hit counter HITS
IDW, 2, width of DONE_ID (log2 NREQ)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
REQ  in  NREQ  request per requester; held until granted
WORD  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
GNT  out  NREQ  one-hot grant pulse, one cycle, in LOAD
BIT  out  1  serial bit to detector
BIT_VALID  out  1  high while BIT carries frame data
DET_RST  out  1  clear to detector RESET input
DET  in  1  detector match output (its STATE)
DONE  out  1  one-cycle frame-complete pulse
DONE_ID  out  IDW  index of requester whose frame finished
HITS  out  CW  DET pulses counted in the frame
BUSY  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock CLK. RESET is synchronous, active-high.
- Reset values: state IDLE, RR pointer 0, and all outputs 0 except DET_RST.
- DET_RST is 1 while RESET is high.
- FSM states: IDLE, LOAD, SHIFT, DRAIN, REPORT.
- IDLE:
  - If any REQ bit is high, pick the first requester at or after the pointer, wrapping modulo NREQ. Latch its index and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - GNT[winner]=1 and DET_RST=1.
  - Shift register <= winner's WORD, bit counter <= 0, hit counter <= 0.
  - Pointer <= (winner+1) mod NREQ.
  - Go to SHIFT.
  - WORD is sampled only in this cycle. The requester may drop or change REQ/WORD after GNT.
- SHIFT (WIDTH cycles):
  - BIT = shift-register MSB and BIT_VALID=1. Shift left by one each cycle.
  - After WIDTH cycles go to DRAIN.
- DRAIN (1 cycle):
  - BIT=0, BIT_VALID=0.
  - Exists to sample the detector's response to the last bit.
- Hit window:
  - win = BIT_VALID delayed by one cycle, so win is high for the WIDTH cycles from SHIFT cycle 2 through DRAIN.
  - On each edge where win=1 and DET=1, the hit counter increments.
  - The counter saturates at 2^CW-1 and never wraps.
  - DET outside the window is ignored.
- REPORT (1 cycle):
  - DONE=1. DONE_ID and HITS are loaded from the frame registers.
  - DONE_ID and HITS are registered and stay stable until the next REPORT.
  - Always returns to IDLE. No direct REPORT->LOAD path.
- Timing and throughput:
  - If REQ is first sampled in IDLE at cycle t0: LOAD is at t0+1, SHIFT spans t0+2..t0+WIDTH+1, DRAIN is at t0+WIDTH+2, and DONE is at t0+WIDTH+3.
  - Back-to-back throughput is one frame per WIDTH+4 cycles.
- DET_RST is high only in LOAD or during RESET.
- GNT is all-zero in every state except LOAD.
- Requests during a frame are not sampled until the next IDLE. A REQ that is still high then competes normally.
- Reset mid-frame:
  - Frame aborted; no DONE or GNT is issued. State returns to IDLE and the pointer to 0.
  - HITS and DONE_ID clear to 0.
- REQ all-zero in IDLE: stay in IDLE with all outputs quiescent; DONE_ID and HITS hold their last values.

Test Plan:
1. REQ=4'b0100, WORD[2]=8'hA5, REQ seen at t0 -> GNT=4'b0100 and DET_RST=1 at t1; BIT=1,0,1,0,0,1,0,1 on t2..t9 with BIT_VALID=1; DONE=1 with DONE_ID=2 at t11; BUSY high t1..t11.
2. Same frame, bench drives DET=1 at t2, t3, t5, t10 -> HITS=3 (t2 outside the window is ignored, t10 DRAIN is counted).
3. REQ=4'b1111 held continuously -> grants in order 0,1,2,3,0. GNT pulses are spaced 12 cycles apart (WIDTH=8).
4. After a grant to requester 1, REQ=4'b0011 -> pointer=2, search wraps, next GNT=4'b0001; the following GNT=4'b0010.
5. CW=3, DET held 1 for the whole frame -> HITS=7 (saturated, not 0).
6. RESET pulsed at t5 mid-SHIFT -> next cycle BIT_VALID=0, BUSY=0, HITS=0, no DONE; DET_RST=1 during reset; with REQ=4'b1111 the next GNT=4'b0001.
